// File: rtl/message_streamer_if.sv
// Streamer bus: control request/abort, UART transmitter handshake and status.
// The controller/bench side uses master; message_streamer uses slave.
interface message_streamer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int SEL_WIDTH  = 2
);
    logic                  start;
    logic [SEL_WIDTH-1:0]  msg_sel;
    logic                  abort;
    logic                  tx_busy;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  new_tx_data;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   byte_count;

    modport master (
        output start, msg_sel, abort, tx_busy,
        input  tx_data, new_tx_data, busy, done, byte_count
    );

    modport slave (
        input  start, msg_sel, abort, tx_busy,
        output tx_data, new_tx_data, busy, done, byte_count
    );
endinterface

// File: rtl/message_streamer.sv
// Streams one NUL-terminated message from a constant ROM into a UART
// transmitter, one strobe per byte, honouring tx_busy back-pressure.
module message_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_MSGS   = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    message_streamer_if.slave bus
);
    localparam int CW      = ADDR_WIDTH + 1;
    localparam int NUM_SEL = 2 ** SEL_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, CHECK} state_t;

    function automatic logic [7:0] rom_byte(input int a);
        logic [7:0] b;
        case (a)
            0:  b = 8'h48;  1:  b = 8'h65;  2:  b = 8'h6C;  3:  b = 8'h6C;
            4:  b = 8'h6F;  5:  b = 8'h20;  6:  b = 8'h57;  7:  b = 8'h6F;
            8:  b = 8'h72;  9:  b = 8'h6C;  10: b = 8'h64;  11: b = 8'h21;
            12: b = 8'h0D;  13: b = 8'h0A;
            15: b = 8'h52;  16: b = 8'h65;  17: b = 8'h61;  18: b = 8'h64;
            19: b = 8'h79;  20: b = 8'h0D;  21: b = 8'h0A;
            23: b = 8'h45;  24: b = 8'h72;  25: b = 8'h72;  26: b = 8'h6F;
            27: b = 8'h72;  28: b = 8'h0D;  29: b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Messages beyond the default four point at the shared empty string.
    function automatic logic [ADDR_WIDTH-1:0] msg_start(input int m);
        case (m)
            0:       return ADDR_WIDTH'(0);
            1:       return ADDR_WIDTH'(15);
            2:       return ADDR_WIDTH'(23);
            default: return ADDR_WIDTH'(31);
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] rom [DEPTH];
    logic [ADDR_WIDTH-1:0] start_addr [NUM_SEL];
    logic [NUM_SEL-1:0]    sel_valid;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign rom[gi] = DATA_WIDTH'(rom_byte(gi));
    end

    for (genvar gi = 0; gi < NUM_SEL; gi++) begin : g_sel
        assign start_addr[gi] = msg_start(gi);
        assign sel_valid[gi]  = (gi < NUM_MSGS);
    end

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  term_reg, term_next;
    logic [DATA_WIDTH-1:0] tx_data_reg, tx_data_next;
    logic                  strobe_reg, strobe_next;
    logic                  done_reg, done_next;
    logic [CW-1:0]         count_reg, count_next;
    logic [DATA_WIDTH-1:0] rom_q;

    // Registered ROM read; addr is held in CHECK so rom_q stays stable.
    always_ff @(posedge clk) begin
        rom_q <= rom[addr_reg];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            term_reg    <= 1'b0;
            tx_data_reg <= '0;
            strobe_reg  <= 1'b0;
            done_reg    <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            term_reg    <= term_next;
            tx_data_reg <= tx_data_next;
            strobe_reg  <= strobe_next;
            done_reg    <= done_next;
            count_reg   <= count_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        term_next    = term_reg;
        tx_data_next = tx_data_reg;
        strobe_next  = 1'b0;
        done_next    = 1'b0;
        count_next   = count_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    addr_next  = start_addr[bus.msg_sel];
                    term_next  = !sel_valid[bus.msg_sel];
                    count_next = '0;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = CHECK;
            CHECK: begin
                if (term_reg || rom_q == '0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (!bus.tx_busy) begin
                    tx_data_next = rom_q;
                    strobe_next  = 1'b1;
                    count_next   = count_reg + CW'(1);
                    state_next   = FETCH;
                    // The last ROM word has no successor: end the message there.
                    if (addr_reg == ADDR_WIDTH'(DEPTH - 1))
                        term_next = 1'b1;
                    else
                        addr_next = addr_reg + ADDR_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort overrides any issue or completion decided above.
        if (bus.abort && state_reg != IDLE) begin
            state_next   = IDLE;
            addr_next    = addr_reg;
            term_next    = term_reg;
            tx_data_next = tx_data_reg;
            strobe_next  = 1'b0;
            done_next    = 1'b0;
            count_next   = count_reg;
        end
    end

    assign bus.tx_data     = tx_data_reg;
    assign bus.new_tx_data = strobe_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = done_reg;
    assign bus.byte_count  = count_reg;
endmodule

// File: tb/tb_message_streamer.sv
// Scoreboard bench for message_streamer: expected bytes are queued from the
// message strings and popped by a monitor on each new_tx_data strobe.
module tb_message_streamer;
    logic clk;
    logic rst;

    message_streamer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .SEL_WIDTH(2)) bus ();

    message_streamer #(
        .DATA_WIDTH(8), .DEPTH(64), .ADDR_WIDTH(6), .NUM_MSGS(4), .SEL_WIDTH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string msgs [4] = '{"Hello World!\r\n", "Ready\r\n", "Error\r\n", ""};

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int strobe_cnt  = 0;
    int done_cnt    = 0;
    int done_cyc    = -1;
    int done_busy   = 0;
    int first_strobe = -1;
    int busy_max    = 0;
    int busy_fixed  = 0;
    int busy_cnt    = 0;
    logic busy_at_edge = 1'b0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        busy_at_edge = bus.tx_busy;
    end

    // UART model: busy for a (fixed or random) number of cycles after each strobe.
    always @(posedge clk) begin
        #1;
        if (rst)
            busy_cnt = 0;
        else if (bus.new_tx_data && busy_max > 0)
            busy_cnt = busy_fixed ? busy_max : int'($urandom_range(1, busy_max));
        else if (busy_cnt > 0)
            busy_cnt--;
        bus.tx_busy = (busy_cnt > 0);
    end

    // Monitor: pop and compare on every strobe.
    always @(negedge clk) begin
        if (bus.new_tx_data) begin
            strobe_cnt++;
            if (first_strobe < 0) first_strobe = cyc;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got byte %0d, expected no strobe", bus.tx_data);
            end else begin
                check("tx_byte", int'(bus.tx_data), int'(exp_q.pop_front()));
            end
            check("strobe_while_tx_busy", int'(busy_at_edge), 0);
            check("done_with_strobe", int'(bus.done), 0);
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = int'(bus.busy);
        end
    end

    task automatic push_msg(input int sel);
        for (int i = 0; i < msgs[sel].len(); i++) exp_q.push_back(8'(msgs[sel].getc(i)));
    endtask

    task automatic wait_idle_tx();
        int k = 0;
        while (bus.tx_busy && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic start_msg(input int sel, output int n);
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.msg_sel = 2'(sel);
        @(posedge clk); #1;
        n = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit);
        int k = 0;
        while (done_cnt == d0 && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        if (done_cnt == d0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done, expected one within %0d cycles", limit);
        end
    endtask

    task automatic run_full(input int sel, input int bmax, input int fixed);
        int n, len, d0;
        busy_max = bmax;
        busy_fixed = fixed;
        wait_idle_tx();
        len = msgs[sel].len();
        push_msg(sel);
        d0 = done_cnt;
        first_strobe = -1;
        start_msg(sel, n);
        wait_done(d0, 3000);
        if (bmax == 0) begin
            check("first_strobe_latency", (first_strobe < 0) ? -1 : first_strobe - n, (len == 0) ? -1 : 2);
            check("done_latency", done_cyc - n, 2 * len + 2);
        end
        check("byte_count", int'(bus.byte_count), len);
        check("busy_at_done", done_busy, 0);
        check("queue_empty", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        check("single_done", done_cnt - d0, 1);
        $display("msg sel=%0d len=%0d busy_max=%0d done_after=%0d", sel, len, bmax, done_cyc - n);
    endtask

    task automatic abort_run(input int sel, input int k, input int d, input int bmax);
        int n, d0, s0, t;
        busy_max = bmax;
        busy_fixed = 0;
        wait_idle_tx();
        push_msg(sel);
        d0 = done_cnt;
        s0 = strobe_cnt;
        start_msg(sel, n);
        t = 0;
        while (strobe_cnt < s0 + k && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        if (strobe_cnt < s0 + k) begin
            vectors++;
            miscompares++;
            $display("FAIL abort_wait_timeout: got %0d strobes, expected %0d", strobe_cnt - s0, k);
        end
        bus.abort = 1'b1;
        repeat (d) @(posedge clk);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        exp_q.delete();
        check("busy_after_abort", int'(bus.busy), 0);
        check("strobe_after_abort", int'(bus.new_tx_data), 0);
        repeat (25) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_byte_count", int'(bus.byte_count), k);
        $display("abort sel=%0d after %0d strobes delay=%0d busy_max=%0d", sel, k, d, bmax);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, d0, len, sel, bmax;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.msg_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_data", int'(bus.tx_data), 0);
        check("rst_new_tx_data", int'(bus.new_tx_data), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_byte_count", int'(bus.byte_count), 0);
        $display("reset checked");
        rst = 1'b0;

        run_full(0, 0, 0);
        run_full(1, 10, 1);
        run_full(3, 0, 0);
        abort_run(0, 5, 0, 0);
        run_full(2, 0, 0);
        abort_run(0, 6, 1, 0);

        // start and abort together in IDLE: start ignored
        @(posedge clk); #1;
        bus.start = 1'b1; bus.abort = 1'b1; bus.msg_sel = 2'd0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start_with_abort_ignored", int'(bus.busy), 0);
        $display("start+abort in idle checked");

        // start re-pulsed while busy
        busy_max = 0;
        wait_idle_tx();
        push_msg(0);
        d0 = done_cnt;
        first_strobe = -1;
        start_msg(0, n);
        for (int i = 0; i < 5; i++) begin
            repeat (3) @(posedge clk);
            #1; bus.start = 1'b1; bus.msg_sel = 2'd1;
            @(posedge clk);
            #1; bus.start = 1'b0;
        end
        wait_done(d0, 200);
        check("repulse_done_latency", done_cyc - n, 30);
        check("repulse_byte_count", int'(bus.byte_count), 14);
        repeat (20) @(negedge clk);
        check("start_not_queued", int'(bus.busy), 0);
        check("repulse_queue_empty", exp_q.size(), 0);
        $display("start re-pulse while busy checked");

        // start held high: back-to-back msg0 with one IDLE cycle
        push_msg(0);
        push_msg(0);
        d0 = done_cnt;
        first_strobe = -1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.msg_sel = 2'd0;
        @(posedge clk); #1;
        n = cyc;
        wait_done(d0, 200);
        check("held_first_done", done_cyc - n, 30);
        check("held_idle_gap", int'(bus.busy), 0);
        first_strobe = -1;
        @(posedge clk); #1;
        n2 = cyc;
        bus.start = 1'b0;
        check("held_rearm_busy", int'(bus.busy), 1);
        wait_done(d0 + 1, 200);
        check("held_second_latency", first_strobe - n2, 2);
        check("held_second_done", done_cyc - n2, 30);
        check("held_byte_count", int'(bus.byte_count), 14);
        check("held_queue_empty", exp_q.size(), 0);
        $display("start held high checked");

        // reset mid-message
        push_msg(0);
        d0 = strobe_cnt;
        start_msg(0, n);
        while (strobe_cnt < d0 + 3 && cyc < n + 100) begin
            @(negedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_tx_data", int'(bus.tx_data), 0);
        check("midrst_new_tx_data", int'(bus.new_tx_data), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_byte_count", int'(bus.byte_count), 0);
        exp_q.delete();
        rst = 1'b0;
        $display("mid-message reset checked");
        run_full(0, 0, 0);

        // randomized messages, back-pressure and aborts
        for (int it = 0; it < 12; it++) begin
            sel = int'($urandom_range(0, 3));
            bmax = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
            len = msgs[sel].len();
            if (len > 0 && $urandom_range(0, 2) == 0)
                abort_run(sel, int'($urandom_range(1, len)), int'($urandom_range(0, 1)), bmax);
            else
                run_full(sel, bmax, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
